// File: rtl/tone_pkg.sv
// Shared types, song data and small helpers for the four-voice tone sequencer.
package tone_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

  localparam logic [14:0] LFSR_SEED = 15'h7FFF;
  // Taps x^15 + x^14 + 1 select register bits 14 and 13.
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  function automatic logic [11:0] note_inc(input logic [4:0] note);
    case (note)
      5'd0:  note_inc = 12'h000;  5'd1:  note_inc = 12'h0AB;  5'd2:  note_inc = 12'h0B5;
      5'd3:  note_inc = 12'h0C0;  5'd4:  note_inc = 12'h0CB;  5'd5:  note_inc = 12'h0D7;
      5'd6:  note_inc = 12'h0E4;  5'd7:  note_inc = 12'h0F2;  5'd8:  note_inc = 12'h100;
      5'd9:  note_inc = 12'h10F;  5'd10: note_inc = 12'h11F;  5'd11: note_inc = 12'h130;
      5'd12: note_inc = 12'h142;  5'd13: note_inc = 12'h155;  5'd14: note_inc = 12'h169;
      5'd15: note_inc = 12'h17E;  5'd16: note_inc = 12'h195;  5'd17: note_inc = 12'h1AD;
      5'd18: note_inc = 12'h1C6;  5'd19: note_inc = 12'h1E1;  5'd20: note_inc = 12'h1FD;
      5'd21: note_inc = 12'h21B;  5'd22: note_inc = 12'h23B;  5'd23: note_inc = 12'h25D;
      5'd24: note_inc = 12'h281;  5'd25: note_inc = 12'h2A7;  5'd26: note_inc = 12'h2CF;
      5'd27: note_inc = 12'h2FA;  5'd28: note_inc = 12'h328;  5'd29: note_inc = 12'h358;
      5'd30: note_inc = 12'h38B;  5'd31: note_inc = 12'h3C1;
      default: note_inc = 12'h000;
    endcase
  endfunction

  // Entry layout is {drum, note[4:0]}.
  function automatic logic [5:0] song_entry(input logic [3:0] idx);
    case (idx)
      4'd0:  song_entry = {1'b0, 5'd8};   4'd1:  song_entry = {1'b0, 5'd8};
      4'd2:  song_entry = {1'b1, 5'd0};   4'd3:  song_entry = {1'b0, 5'd12};
      4'd4:  song_entry = {1'b1, 5'd15};  4'd5:  song_entry = {1'b0, 5'd0};
      4'd6:  song_entry = {1'b1, 5'd20};  4'd7:  song_entry = {1'b0, 5'd13};
      4'd8:  song_entry = {1'b1, 5'd8};   4'd9:  song_entry = {1'b0, 5'd10};
      4'd10: song_entry = {1'b1, 5'd0};   4'd11: song_entry = {1'b0, 5'd31};
      4'd12: song_entry = {1'b1, 5'd24};  4'd13: song_entry = {1'b0, 5'd17};
      4'd14: song_entry = {1'b1, 5'd1};   4'd15: song_entry = {1'b0, 5'd5};
      default: song_entry = 6'h00;
    endcase
  endfunction

  function automatic logic [14:0] lfsr_next(input logic [14:0] l);
    lfsr_next = {l[13:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] tri_fold(input logic msb, input logic [3:0] t);
    tri_fold = msb ? ~t : t;
  endfunction

endpackage

// File: rtl/tone_seq_phase_acc.sv
// Phase accumulator for one voice; clear takes priority over advance.
module phase_acc #(
  parameter int PHASE_W = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ena,
  input  logic               adv,
  input  logic               clr,
  input  logic [PHASE_W-1:0] inc,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] r_phase;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (ena) begin
      if (clr) begin
        r_phase <= '0;
      end else if (adv) begin
        r_phase <= r_phase + inc;
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/tone_seq.sv
// Four-voice tone sequencer: song ROM playback stepped once per scan-line strobe,
// producing triangle, two square and a gated-noise 4-bit sample stream.
module tone_seq
  import tone_pkg::*;
#(
  parameter int LINES_PER_NOTE = 1024,
  parameter int PHASE_W        = 12,
  parameter int SONG_LEN       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       step,
  input  logic       run,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] s3,
  output logic [3:0] s4,
  output logic       beat,
  output logic       bar
);

  localparam int CNT_W = $clog2(LINES_PER_NOTE + 1);
  localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_line;
  logic [IDX_W-1:0]   r_idx;
  logic [14:0]        r_lfsr;
  logic [3:0]         r_s1, r_s2, r_s3, r_s4;
  logic               r_beat, r_bar;

  logic [5:0]         w_entry;
  logic               w_drum, w_rest, w_last, w_adv, w_clr;
  logic [PHASE_W-1:0] w_inc, w_inc_bass;
  logic [PHASE_W-1:0] w_ph1, w_ph2, w_ph3, w_ph1_nx, w_ph2_nx, w_ph3_nx;
  logic [14:0]        w_lfsr_nx;

  assign w_entry    = song_entry(4'(r_idx));
  assign w_drum     = w_entry[5];
  assign w_rest     = (w_entry[4:0] == 5'd0);
  assign w_inc      = PHASE_W'(note_inc(w_entry[4:0]));
  assign w_inc_bass = w_inc >> 1;
  assign w_adv      = (r_state == ST_PLAY) && run && step;
  assign w_clr      = !run;
  assign w_last     = (r_line == CNT_W'(LINES_PER_NOTE - 1));
  assign w_lfsr_nx  = lfsr_next(r_lfsr);

  // Samples are taken from the post-step phases so they land one clock after the strobe.
  assign w_ph1_nx = w_ph1 + w_inc;
  assign w_ph2_nx = w_ph2 + w_inc;
  assign w_ph3_nx = w_ph3 + w_inc_bass;

  phase_acc #(.PHASE_W(PHASE_W)) u_ph1 (
    .clock(clock), .reset_n(reset_n), .ena(ena), .adv(w_adv), .clr(w_clr),
    .inc(w_inc), .phase(w_ph1)
  );
  phase_acc #(.PHASE_W(PHASE_W)) u_ph2 (
    .clock(clock), .reset_n(reset_n), .ena(ena), .adv(w_adv), .clr(w_clr),
    .inc(w_inc), .phase(w_ph2)
  );
  phase_acc #(.PHASE_W(PHASE_W)) u_ph3 (
    .clock(clock), .reset_n(reset_n), .ena(ena), .adv(w_adv), .clr(w_clr),
    .inc(w_inc_bass), .phase(w_ph3)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_line  <= '0;
      r_idx   <= '0;
      r_lfsr  <= LFSR_SEED;
      r_s1    <= 4'h0;
      r_s2    <= 4'h0;
      r_s3    <= 4'h0;
      r_s4    <= 4'h0;
      r_beat  <= 1'b0;
      r_bar   <= 1'b0;
    end else begin
      r_beat <= 1'b0;
      r_bar  <= 1'b0;
      if (ena) begin
        case (r_state)
          ST_IDLE: begin
            if (run) r_state <= ST_PLAY;
          end
          ST_PLAY: begin
            if (!run) begin
              r_state <= ST_IDLE;
              r_line  <= '0;
              r_idx   <= '0;
              r_s1    <= 4'h0;
              r_s2    <= 4'h0;
              r_s3    <= 4'h0;
              r_s4    <= 4'h0;
            end else if (step) begin
              r_lfsr <= w_lfsr_nx;
              if (w_last) begin
                r_line <= '0;
                r_idx  <= r_idx + IDX_W'(1);
                r_beat <= 1'b1;
                r_bar  <= (r_idx == IDX_W'(SONG_LEN - 1));
              end else begin
                r_line <= r_line + CNT_W'(1);
              end
              r_s1 <= w_rest ? 4'h0 : tri_fold(w_ph1_nx[PHASE_W-1], w_ph1_nx[PHASE_W-2 -: 4]);
              r_s2 <= w_rest ? 4'h0 : {4{w_ph2_nx[PHASE_W-1]}};
              r_s3 <= w_rest ? 4'h0 : {4{w_ph3_nx[PHASE_W-1]}};
              r_s4 <= w_drum ? {4{w_lfsr_nx[0]}} : 4'h0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s1   = r_s1;
  assign s2   = r_s2;
  assign s3   = r_s3;
  assign s4   = r_s4;
  assign beat = r_beat;
  assign bar  = r_bar;

endmodule

// File: tb/tb_tone_seq.sv
// Self-checking bench for tone_seq: randomized stimulus against an arithmetic
// reference model of the sequencer, plus directed scenario checks.
module tb_tone_seq;
  import tone_pkg::*;

  localparam int LPN  = 4;
  localparam int SLEN = 16;

  logic       clock = 1'b0;
  logic       reset_n, ena, step, run;
  logic [3:0] s1, s2, s3, s4;
  logic       beat, bar;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int   m_play, m_line, m_idx, m_ph1, m_ph2, m_ph3, m_lfsr;
  int   m_s1, m_s2, m_s3, m_s4;
  logic m_beat, m_bar;
  logic [17:0] m_out;

  always #5 clock = ~clock;

  tone_seq #(.LINES_PER_NOTE(LPN), .PHASE_W(12), .SONG_LEN(SLEN)) dut (
    .clock(clock), .reset_n(reset_n), .ena(ena), .step(step), .run(run),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .beat(beat), .bar(bar)
  );

  task automatic model_edge();
    int entry, note, drum, inc, t;
    m_beat = 1'b0;
    m_bar  = 1'b0;
    if (!reset_n) begin
      m_play = 0; m_line = 0; m_idx = 0;
      m_ph1 = 0; m_ph2 = 0; m_ph3 = 0; m_lfsr = 32'h7FFF;
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_s4 = 0;
    end else if (ena) begin
      if (m_play == 0) begin
        if (run) m_play = 1;
      end else if (!run) begin
        m_play = 0; m_line = 0; m_idx = 0;
        m_ph1 = 0; m_ph2 = 0; m_ph3 = 0;
        m_s1 = 0; m_s2 = 0; m_s3 = 0; m_s4 = 0;
      end else if (step) begin
        entry  = int'(song_entry(4'(m_idx)));
        note   = entry % 32;
        drum   = entry / 32;
        inc    = int'(note_inc(5'(note)));
        m_ph1  = (m_ph1 + inc) % 4096;
        m_ph2  = (m_ph2 + inc) % 4096;
        m_ph3  = (m_ph3 + inc / 2) % 4096;
        m_lfsr = ((m_lfsr * 2) % 32768) + (((m_lfsr / 16384) + (m_lfsr / 8192)) % 2);
        m_line = m_line + 1;
        if (m_line == LPN) begin
          m_line = 0;
          m_beat = 1'b1;
          m_idx  = (m_idx + 1) % SLEN;
          m_bar  = (m_idx == 0);
        end
        t = (m_ph1 / 128) % 16;
        if (note == 0) begin
          m_s1 = 0; m_s2 = 0; m_s3 = 0;
        end else begin
          m_s1 = (m_ph1 >= 2048) ? 15 - t : t;
          m_s2 = (m_ph2 >= 2048) ? 15 : 0;
          m_s3 = (m_ph3 >= 2048) ? 15 : 0;
        end
        m_s4 = (drum != 0 && (m_lfsr % 2) == 1) ? 15 : 0;
      end
    end
    m_out = {4'(m_s1), 4'(m_s2), 4'(m_s3), 4'(m_s4), m_beat, m_bar};
  endtask

  task automatic tick(input logic e, input logic st, input logic r);
    ena  = e;
    step = st;
    run  = r;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      n_vec++;
      if ({s1, s2, s3, s4, beat, bar} !== 18'h0) begin
        n_err++;
        $display("FAIL reset_hold: got %h want %h", {s1, s2, s3, s4, beat, bar}, 18'h0);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_vec++;
      if ({s1, s2, s3, s4, beat, bar} !== m_out) begin
        n_err++;
        $display("FAIL reset_release: got %h want %h", {s1, s2, s3, s4, beat, bar}, m_out);
      end
    end
  endtask

  task automatic test_triangle();
    logic [3:0] tri_exp [8];
    tri_exp = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd15};
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      n_vec++;
      if (s1 !== tri_exp[i] || s2 !== ((i == 7) ? 4'hF : 4'h0)) begin
        n_err++;
        $display("FAIL triangle[%0d]: got s1=%h s2=%h want s1=%h", i, s1, s2, tri_exp[i]);
      end
      n_vec++;
      if ({s1, s2, s3, s4, beat, bar} !== m_out) begin
        n_err++;
        $display("FAIL triangle_model[%0d]: got %h want %h", i, {s1, s2, s3, s4, beat, bar}, m_out);
      end
    end
  endtask

  task automatic test_note_advance();
    int n_beat, n_bar, bar_at;
    n_beat = 0; n_bar = 0; bar_at = -1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        if (beat) n_beat++;
        if (bar) n_bar++;
      end
      tick(1'b1, 1'b1, 1'b1);
      if (beat) n_beat++;
      if (bar) begin n_bar++; bar_at = n_beat; end
      n_vec++;
      if ({s1, s2, s3, s4, beat, bar} !== m_out) begin
        n_err++;
        $display("FAIL advance_model[%0d]: got %h want %h", i, {s1, s2, s3, s4, beat, bar}, m_out);
      end
    end
    n_vec++;
    if (n_beat != 16 || n_bar != 1 || bar_at != 16) begin
      n_err++;
      $display("FAIL advance_counts: got beats=%0d bars=%0d bar_at=%0d want 16 1 16", n_beat, n_bar, bar_at);
    end
  endtask

  task automatic test_simultaneous();
    logic [17:0] held;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
    held = {s1, s2, s3, s4, beat, bar};
    tick(1'b0, 1'b1, 1'b1);
    n_vec++;
    if ({s1, s2, s3, s4, beat, bar} !== {held[17:2], 2'b00}) begin
      n_err++;
      $display("FAIL ena_low_step: got %h want %h", {s1, s2, s3, s4, beat, bar}, {held[17:2], 2'b00});
    end
    tick(1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({s1, s2, s3, s4, beat, bar} !== 18'h0) begin
      n_err++;
      $display("FAIL step_run_fall: got %h want %h", {s1, s2, s3, s4, beat, bar}, 18'h0);
    end
    tick(1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({s1, s2, s3, s4, beat, bar} !== 18'h0) begin
      n_err++;
      $display("FAIL run_rise_step: got %h want %h", {s1, s2, s3, s4, beat, bar}, 18'h0);
    end
    tick(1'b1, 1'b1, 1'b1);
    n_vec++;
    if (s1 !== 4'd2 || {s1, s2, s3, s4, beat, bar} !== m_out) begin
      n_err++;
      $display("FAIL phase_cleared: got %h want %h", {s1, s2, s3, s4, beat, bar}, m_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) != 0));
      n_vec++;
      if ({s1, s2, s3, s4, beat, bar} !== m_out) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, {s1, s2, s3, s4, beat, bar}, m_out);
      end
    end
  endtask

  task automatic test_back_to_back_lfsr();
    int fails;
    fails = 0;
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 32767; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      n_vec++;
      if ({s1, s2, s3, s4, beat, bar} !== m_out) begin
        n_err++;
        fails++;
        if (fails <= 10)
          $display("FAIL lfsr_run[%0d]: got %h want %h", i, {s1, s2, s3, s4, beat, bar}, m_out);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ena     = 1'b0;
    step    = 1'b0;
    run     = 1'b0;
    m_out   = 18'h0;
    @(negedge clock);
    test_reset();
    test_triangle();
    test_note_advance();
    test_simultaneous();
    test_random();
    test_back_to_back_lfsr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
